// File: rtl/pipe_trace_buf_if.sv
// ----------------------------------------------------------------------------
// pipe_trace_buf_if
//
// Purpose:
//   Groups the MEM-stage watch bus, the arm/trigger controls and the trace
//   read port of pipe_trace_buf into one bundle. Clock and reset are kept
//   outside the bundle.
//
// Modports:
//   master - the side that drives the watch bus, arm/trigger and read
//            requests (pipeline glue, firmware bridge or a bench)
//   slave  - the trace buffer itself
//
// Signals:
//   valid_i, pc_next_i, alu_i, data_i, wbaddr_i, instr_i  watch bus
//   arm_i, trig_pc_i                                      capture control
//   rd_en_i, rd_idx_i                                     read request
//   rd_valid_o, rd_pc_o, rd_alu_o, rd_data_o,
//   rd_wbaddr_o, rd_instr_o                               read data
//   count_o, trig_pos_o, armed_o, done_o                  status
// ----------------------------------------------------------------------------
interface pipe_trace_buf_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PTR_W  = 4
);
    logic              valid_i;
    logic [DATA_W-1:0] pc_next_i;
    logic [DATA_W-1:0] alu_i;
    logic [DATA_W-1:0] data_i;
    logic [REG_W-1:0]  wbaddr_i;
    logic [DATA_W-1:0] instr_i;
    logic              arm_i;
    logic [DATA_W-1:0] trig_pc_i;
    logic              rd_en_i;
    logic [PTR_W-1:0]  rd_idx_i;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_pc_o;
    logic [DATA_W-1:0] rd_alu_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [REG_W-1:0]  rd_wbaddr_o;
    logic [DATA_W-1:0] rd_instr_o;
    logic [PTR_W:0]    count_o;
    logic [PTR_W-1:0]  trig_pos_o;
    logic              armed_o;
    logic              done_o;

    modport master (
        output valid_i, pc_next_i, alu_i, data_i, wbaddr_i, instr_i,
        output arm_i, trig_pc_i, rd_en_i, rd_idx_i,
        input  rd_valid_o, rd_pc_o, rd_alu_o, rd_data_o, rd_wbaddr_o, rd_instr_o,
        input  count_o, trig_pos_o, armed_o, done_o
    );

    modport slave (
        input  valid_i, pc_next_i, alu_i, data_i, wbaddr_i, instr_i,
        input  arm_i, trig_pc_i, rd_en_i, rd_idx_i,
        output rd_valid_o, rd_pc_o, rd_alu_o, rd_data_o, rd_wbaddr_o, rd_instr_o,
        output count_o, trig_pos_o, armed_o, done_o
    );
endinterface

// File: rtl/pipe_trace_buf.sv
// ----------------------------------------------------------------------------
// pipe_trace_buf
//
// Purpose:
//   On-chip trace capture for the MEM-stage watch bus of the 5-stage core.
//   After an arm pulse every retiring instruction is written into a circular
//   buffer of DEPTH entries. A pc_next match against trig_pc_i starts a
//   window of POST_CNT further entries, after which the buffer freezes so
//   the history around the event can be read back. Pure observer: it never
//   stalls the pipeline.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - pipe_trace_buf_if.slave: watch bus, arm/trigger, read port, status
//
// Optional feature:
//   TRACE_SKIP_NOP_EN - when defined, canonical nops (addi x0,x0,0) are not
//   stored and do not advance the post-trigger window; they may still trigger.
// ----------------------------------------------------------------------------
module pipe_trace_buf #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int DEPTH    = 16,
    parameter int PTR_W    = 4,
    parameter int POST_CNT = 8
) (
    input logic clk,
    input logic rst,
    pipe_trace_buf_if.slave bus
);

    localparam int ENTRY_W = 4 * DATA_W + REG_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] POST_P  = PTR_W'(POST_CNT);

    logic [1:0]         r_state;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W-1:0]   r_postCnt;
    logic [PTR_W-1:0]   r_trigPos;

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    logic               r_rdValid;
    logic [DATA_W-1:0]  r_rdPc;
    logic [DATA_W-1:0]  r_rdAlu;
    logic [DATA_W-1:0]  r_rdData;
    logic [REG_W-1:0]   r_rdWbaddr;
    logic [DATA_W-1:0]  r_rdInstr;

    logic               w_cap;
    logic               w_hit;
    logic               w_store;
    logic [PTR_W:0]     w_countNext;
    logic [PTR_W-1:0]   w_trigPosNext;
    logic [ENTRY_W-1:0] w_entry;
    logic [PTR_W-1:0]   w_rdAddr;
    logic               w_rdInRange;

    // An arm pulse takes priority over any capture in the same cycle, so the
    // capture qualifier already excludes it; the trigger is only live in ARMED.
    assign w_cap = bus.valid_i && !bus.arm_i &&
                   ((r_state == S_ARMED) || (r_state == S_POST));
    assign w_hit = w_cap && (r_state == S_ARMED) && (bus.pc_next_i == bus.trig_pc_i);

`ifdef TRACE_SKIP_NOP_EN
    logic w_isNop;
    logic r_trigNop;
    logic w_trigNop;

    assign w_isNop = (bus.instr_i == DATA_W'(32'h0000_0013));
    assign w_store = w_cap && !w_isNop;
`else
    assign w_store = w_cap;
`endif

    // Count saturates at DEPTH; once full, each new entry overwrites the oldest.
    assign w_countNext = !w_store ? r_count :
                         (r_count == DEPTH_C) ? r_count : r_count + 1'b1;

    assign w_entry = {bus.pc_next_i, bus.alu_i, bus.data_i, bus.wbaddr_i, bus.instr_i};

    // Index 0 is the oldest stored entry. When full, count's low bits are
    // zero, so the oldest entry is the one wr_ptr is about to overwrite.
    assign w_rdAddr    = r_wrPtr - r_count[PTR_W-1:0] + bus.rd_idx_i;
    assign w_rdInRange = ({1'b0, bus.rd_idx_i} < r_count);

`ifdef TRACE_SKIP_NOP_EN
    // Remember whether the triggering instruction was a nop so the trigger
    // position can be pointed at the next stored entry when the window closes.
    assign w_trigNop = (r_state == S_ARMED) ? w_isNop : r_trigNop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_trigNop <= 1'b0;
        end else if (bus.arm_i) begin
            r_trigNop <= 1'b0;
        end else if (w_hit) begin
            r_trigNop <= w_isNop;
        end
    end

    // A stored trigger sits POST_CNT+1 entries from the end. An unstored
    // (nop) trigger leaves the following entry at POST_CNT from the end,
    // clamped into the populated range.
    always_comb begin
        w_trigPosNext = w_countNext[PTR_W-1:0] - POST_P - PTR_W'(1);
        if (w_trigNop) begin
            if (w_countNext == '0) begin
                w_trigPosNext = '0;
            end else if (POST_CNT == 0) begin
                w_trigPosNext = w_countNext[PTR_W-1:0] - PTR_W'(1);
            end else if (w_countNext < (PTR_W + 1)'(POST_CNT)) begin
                w_trigPosNext = '0;
            end else begin
                w_trigPosNext = PTR_W'(w_countNext - (PTR_W + 1)'(POST_CNT));
            end
        end
    end
`else
    // The trigger entry sits POST_CNT+1 entries from the end of the final
    // buffer; the PTR_W-bit wrap handles count == DEPTH.
    assign w_trigPosNext = w_countNext[PTR_W-1:0] - POST_P - PTR_W'(1);
`endif

    // Control FSM plus write pointer, fill count, post-trigger window and
    // trigger position. Arm clears the capture and restarts from ARMED in
    // any state; DONE holds everything frozen until the next arm or reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_postCnt <= '0;
            r_trigPos <= '0;
        end else if (bus.arm_i) begin
            r_state   <= S_ARMED;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_postCnt <= '0;
            r_trigPos <= '0;
        end else begin
            if (w_store) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                r_count <= w_countNext;
            end
            case (r_state)
                S_ARMED: begin
                    if (w_hit) begin
                        if (POST_CNT == 0) begin
                            r_state   <= S_DONE;
                            r_trigPos <= w_trigPosNext;
                        end else begin
                            r_state   <= S_POST;
                            r_postCnt <= POST_P;
                        end
                    end
                end
                S_POST: begin
                    if (w_store) begin
                        r_postCnt <= r_postCnt - 1'b1;
                        if (r_postCnt == PTR_W'(1)) begin
                            r_state   <= S_DONE;
                            r_trigPos <= w_trigPosNext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Trace RAM: write-only from the capture side, no reset on contents.
    always_ff @(posedge clk) begin
        if (rst && w_store) begin
            r_mem[r_wrPtr] <= w_entry;
        end
    end

    // Registered read port. Reading the RAM in the same edge as a capture
    // write returns the old contents, which is the intended pre-write view.
    // Out-of-range indices return all-zero fields; idle cycles hold the data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdValid  <= 1'b0;
            r_rdPc     <= '0;
            r_rdAlu    <= '0;
            r_rdData   <= '0;
            r_rdWbaddr <= '0;
            r_rdInstr  <= '0;
        end else if (bus.rd_en_i) begin
            if (w_rdInRange) begin
                r_rdValid <= 1'b1;
                {r_rdPc, r_rdAlu, r_rdData, r_rdWbaddr, r_rdInstr} <= r_mem[w_rdAddr];
            end else begin
                r_rdValid  <= 1'b0;
                r_rdPc     <= '0;
                r_rdAlu    <= '0;
                r_rdData   <= '0;
                r_rdWbaddr <= '0;
                r_rdInstr  <= '0;
            end
        end else begin
            r_rdValid <= 1'b0;
        end
    end

    assign bus.rd_valid_o  = r_rdValid;
    assign bus.rd_pc_o     = r_rdPc;
    assign bus.rd_alu_o    = r_rdAlu;
    assign bus.rd_data_o   = r_rdData;
    assign bus.rd_wbaddr_o = r_rdWbaddr;
    assign bus.rd_instr_o  = r_rdInstr;
    assign bus.count_o     = r_count;
    assign bus.trig_pos_o  = (r_state == S_DONE) ? r_trigPos : '0;
    assign bus.armed_o     = (r_state == S_ARMED) || (r_state == S_POST);
    assign bus.done_o      = (r_state == S_DONE);

endmodule
